// File: rtl/illegal_instruction_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | illegal_instruction_pipe_if : fetch-side and decode-side handshake bundle |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface illegal_instruction_pipe_if #(
    parameter int ID_W = 3
) ();
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instruction;
    logic [ID_W-1:0] in_id;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instruction;
    logic [ID_W-1:0] out_id;
    logic            out_illegal;
    logic [2:0]      out_class;

    modport master (
        output in_valid, in_instruction, in_id, out_ready,
        input  in_ready, out_valid, out_instruction, out_id, out_illegal, out_class
    );

    modport slave (
        input  in_valid, in_instruction, in_id, out_ready,
        output in_ready, out_valid, out_instruction, out_id, out_illegal, out_class
    );
endinterface
`default_nettype wire

// File: rtl/illegal_instruction_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | illegal_instruction_pipe : back-pressurable RV32 legality classifier     |
// | with first-illegal capture and saturating illegal counter. Revision: 1.0 |
// +--------------------------------------------------------------------------+
module illegal_instruction_pipe #(
    parameter int PIPE_STAGES    = 2,
    parameter int ID_W           = 3,
    parameter int RCA_NUM_FUNCT7 = 8,
    parameter int COUNT_W        = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic [5:0]                ext_enable_i,
    illegal_instruction_pipe_if.slave pipe_if,
    input  logic                      capture_clear_i,
    input  logic                      count_clear_i,
    output logic                      capture_valid_o,
    output logic [31:0]               capture_instruction_o,
    output logic [ID_W-1:0]           capture_id_o,
    output logic [COUNT_W-1:0]        illegal_count_o
);

    localparam int               c_last      = PIPE_STAGES - 1;
    localparam logic [7:0]       c_rca_limit = 8'(RCA_NUM_FUNCT7);
    localparam logic [COUNT_W-1:0] c_count_max = '1;
    localparam logic [2:0] c_cls_base = 3'd0;
    localparam logic [2:0] c_cls_mul  = 3'd1;
    localparam logic [2:0] c_cls_div  = 3'd2;
    localparam logic [2:0] c_cls_amo  = 3'd3;
    localparam logic [2:0] c_cls_sys  = 3'd4;
    localparam logic [2:0] c_cls_rca  = 3'd5;
    localparam logic [2:0] c_cls_ill  = 3'd7;

    // Anything not explicitly recognised (or recognised but disabled) falls to c_cls_ill.
    function automatic logic [2:0] classify(input logic [31:0] ins, input logic [5:0] en);
        logic [6:0] f7;
        logic [2:0] f3;
        logic [2:0] cls;
        f7  = ins[31:25];
        f3  = ins[14:12];
        cls = c_cls_ill;
        case (ins[6:0])
            7'b0110111, 7'b0010111, 7'b1101111: cls = c_cls_base;
            7'b1100111: if (f3 == 3'b000) cls = c_cls_base;
            7'b1100011: if (f3 != 3'b010 && f3 != 3'b011) cls = c_cls_base;
            7'b0000011: if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) cls = c_cls_base;
            7'b0100011: if (!f3[2] && f3 != 3'b011) cls = c_cls_base;
            7'b0010011: begin
                if (f3 == 3'b001) begin
                    if (f7 == 7'b0000000) cls = c_cls_base;
                end else if (f3 == 3'b101) begin
                    if (f7 == 7'b0000000 || f7 == 7'b0100000) cls = c_cls_base;
                end else begin
                    cls = c_cls_base;
                end
            end
            7'b0110011: begin
                if (f7 == 7'b0000000) begin
                    cls = c_cls_base;
                end else if (f7 == 7'b0100000) begin
                    if (f3 == 3'b000 || f3 == 3'b101) cls = c_cls_base;
                end else if (f7 == 7'b0000001) begin
                    if (!f3[2]) begin
                        if (en[0]) cls = c_cls_mul;
                    end else if (en[1]) begin
                        cls = c_cls_div;
                    end
                end
            end
            7'b0001111: if (f3[2:1] == 2'b00) cls = c_cls_base;
            7'b1110011: begin
                if (f3 != 3'b000 && f3 != 3'b100) begin
                    cls = c_cls_base;
                end else if (ins == 32'h00000073 || ins == 32'h00100073 || ins == 32'h30200073) begin
                    if (en[3]) cls = c_cls_sys;
                end else if (ins == 32'h10200073 || ins == 32'h10500073 ||
                             (f3 == 3'b000 && f7 == 7'b0001001 && ins[11:7] == 5'd0)) begin
                    if (en[4]) cls = c_cls_sys;
                end
            end
            7'b0101111: begin
                if (f3 == 3'b010 && en[2]) begin
                    case (ins[31:27])
                        5'b00010: if (ins[24:20] == 5'd0) cls = c_cls_amo;
                        5'b00011, 5'b00001, 5'b00000, 5'b00100, 5'b01100,
                        5'b01000, 5'b10000, 5'b10100, 5'b11000, 5'b11100: cls = c_cls_amo;
                        default: cls = c_cls_ill;
                    endcase
                end
            end
            7'b0101011: if (!f3[2] && en[5] && ({1'b0, f7} < c_rca_limit)) cls = c_cls_rca;
            default: cls = c_cls_ill;
        endcase
        return cls;
    endfunction

    logic [PIPE_STAGES-1:0] valid_q;
    logic [PIPE_STAGES-1:0] valid_d;
    logic [PIPE_STAGES-1:0] stage_ready;
    logic [31:0]            instr_q [PIPE_STAGES];
    logic [31:0]            instr_d [PIPE_STAGES];
    logic [ID_W-1:0]        id_q    [PIPE_STAGES];
    logic [ID_W-1:0]        id_d    [PIPE_STAGES];
    logic [2:0]             class_q [PIPE_STAGES];
    logic [2:0]             class_d [PIPE_STAGES];

    // ext_enable is folded into the class at accept, so later enable changes cannot touch in-flight entries.
    assign valid_d[0] = pipe_if.in_valid;
    assign instr_d[0] = pipe_if.in_instruction;
    assign id_d[0]    = pipe_if.in_id;
    assign class_d[0] = classify(pipe_if.in_instruction, ext_enable_i);

    for (genvar k = 1; k < PIPE_STAGES; k++) begin : g_link
        assign valid_d[k] = valid_q[k-1];
        assign instr_d[k] = instr_q[k-1];
        assign id_d[k]    = id_q[k-1];
        assign class_d[k] = class_q[k-1];
    end

    // Stage k can move when any stage from k to the tail has a hole, or the consumer takes the tail.
    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_ready
        assign stage_ready[k] = pipe_if.out_ready || (valid_q[PIPE_STAGES-1:k] != '1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                instr_q[k] <= '0;
                id_q[k]    <= '0;
                class_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                if (flush_i) begin
                    valid_q[k] <= 1'b0;
                end else if (stage_ready[k]) begin
                    valid_q[k] <= valid_d[k];
                    if (valid_d[k]) begin
                        instr_q[k] <= instr_d[k];
                        id_q[k]    <= id_d[k];
                        class_q[k] <= class_d[k];
                    end
                end
            end
        end
    end

    logic out_illegal;
    logic ill_handshake;

    assign out_illegal             = (class_q[c_last] == c_cls_ill);
    assign pipe_if.in_ready        = stage_ready[0] && !flush_i;
    assign pipe_if.out_valid       = valid_q[c_last];
    assign pipe_if.out_instruction = instr_q[c_last];
    assign pipe_if.out_id          = id_q[c_last];
    assign pipe_if.out_class       = class_q[c_last];
    assign pipe_if.out_illegal     = out_illegal;
    assign ill_handshake           = valid_q[c_last] && pipe_if.out_ready && out_illegal;

    logic                capture_valid_q;
    logic [31:0]         capture_instr_q;
    logic [ID_W-1:0]     capture_id_q;
    logic [COUNT_W-1:0]  count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            capture_valid_q <= 1'b0;
            capture_instr_q <= '0;
            capture_id_q    <= '0;
            count_q         <= '0;
        end else begin
            // A clear in the same cycle as an illegal retire hands the slot straight to the new one.
            if (ill_handshake && (!capture_valid_q || capture_clear_i)) begin
                capture_valid_q <= 1'b1;
                capture_instr_q <= instr_q[c_last];
                capture_id_q    <= id_q[c_last];
            end else if (capture_clear_i) begin
                capture_valid_q <= 1'b0;
            end

            if (count_clear_i) begin
                count_q <= ill_handshake ? COUNT_W'(1) : '0;
            end else if (ill_handshake && count_q != c_count_max) begin
                count_q <= count_q + COUNT_W'(1);
            end
        end
    end

    assign capture_valid_o       = capture_valid_q;
    assign capture_instruction_o = capture_instr_q;
    assign capture_id_o          = capture_id_q;
    assign illegal_count_o       = count_q;

endmodule
`default_nettype wire
